uart_rx_byte: RTL and testbench

Serial receive front end for the UART program-load path. It oversamples the asynchronous `rxd` line on the memory clock and deframes 8N1 characters, LSB first. Each good character is presented as `progData` with a one-cycle `progValid` strobe. Those two outputs drive the byte-to-word packer's `progData`/`progValid` inputs directly. Framing errors are flagged and never forwarded.

---
 rtl/uart_rx_byte.sv | 123 ++++++++++++
 tb/tb_uart_rx_byte.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver for the program-load path: synchronizes rxd, deframes
// LSB-first characters and strobes each good byte out on progData/progValid.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clkMem,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rxEn,
  output logic [7:0] progData,
  output logic       progValid,
  output logic       frameErr,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a falling edge on the synchronized line
  // START | counting to the middle of the start bit, then confirming it is low
  // DATA  | sampling the 8 data bits at mid-bit, LSB first
  // STOP  | sampling the stop bit; high delivers the byte, low flags a framing error

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rxMeta;
  logic          rxs;
  logic          rxq;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          fallEdge;

  assign fallEdge = rxq & ~rxs;
  assign busy     = (state != IDLE);

  always_ff @(posedge clkMem) begin
    if (rst) begin
      rxMeta    <= 1'b1;
      rxs       <= 1'b1;
      rxq       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      progData  <= '0;
      progValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxMeta    <= rxd;
      rxs       <= rxMeta;
      rxq       <= rxs;
      progValid <= 1'b0;
      frameErr  <= 1'b0;

      if (!rxEn) begin
        // Disabling mid-frame drops the partial character silently
        state  <= IDLE;
        cnt    <= '0;
        bitIdx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fallEdge) begin
              state <= START;
              cnt   <= '0;
            end
          end

          START: begin
            if (cnt == HALF_TC) begin
              cnt <= '0;
              if (!rxs) begin
                state  <= DATA;
                bitIdx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == BIT_TC) begin
              cnt      <= '0;
              shiftReg <= {rxs, shiftReg[7:1]};
              bitIdx   <= bitIdx + 3'd1;
              if (bitIdx == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STOP: begin
            if (cnt == BIT_TC) begin
              // Back to IDLE while the strobe is high so a zero-idle next start is caught
              cnt   <= '0;
              state <= IDLE;
              if (rxs) begin
                progData  <= shiftReg;
                progValid <= 1'b1;
              end else begin
                frameErr <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit, 20 ns clock.
module tb_uart_rx_byte;

  logic       clkMem;
  logic       rst;
  logic       rxd;
  logic       rxEn;
  logic [7:0] progData;
  logic       progValid;
  logic       frameErr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] vq[$];
  int         vt[$];
  int         feCnt = 0;
  int         ruleViol = 0;
  logic       prevV = 1'b0;
  logic       prevF = 1'b0;

  uart_rx_byte #(.CLKS_PER_BIT(16)) dut (
    .clkMem(clkMem),
    .rst(rst),
    .rxd(rxd),
    .rxEn(rxEn),
    .progData(progData),
    .progValid(progValid),
    .frameErr(frameErr),
    .busy(busy)
  );

  initial clkMem = 1'b0;
  always #10 clkMem = ~clkMem;

  always @(posedge clkMem) cyc++;

  always @(negedge clkMem) begin
    if (progValid) begin
      vq.push_back(progData);
      vt.push_back(cyc);
    end
    if (frameErr) feCnt++;
    if ((progValid && frameErr) || (progValid && prevV) || (frameErr && prevF)) ruleViol++;
    prevV = progValid;
    prevF = frameErr;
  end

  task automatic clearLog();
    vq.delete();
    vt.delete();
    feCnt = 0;
  endtask

  // Caller is at a negedge; returns at the negedge exactly 10 bit-times later.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int st);
    rxd = 1'b0;
    st = cyc;
    repeat (16) @(negedge clkMem);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clkMem);
    end
    rxd = stopBit;
    repeat (16) @(negedge clkMem);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clkMem);
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rxEn = 1'b1;
    repeat (3) @(negedge clkMem);
    checks++;
    if ({progData, progValid, frameErr, busy} !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b, expected 00/0/0/0",
               progData, progValid, frameErr, busy);
    end
    rst = 1'b0;
    idle(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    int st;
    clearLog();
    sendFrame(8'h02, 1'b1, st);
    idle(20);
    checks++;
    if (vq.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d pulses expected 1", vq.size());
    end else begin
      checks++;
      if (vq[0] !== 8'h02) begin
        errors++;
        $display("FAIL single_data: got %h expected 02", vq[0]);
      end
      checks++;
      if (vt[0] != st + 155) begin
        errors++;
        $display("FAIL single_latency: got cycle %0d expected %0d", vt[0], st + 155);
      end
    end
    checks++;
    if (feCnt != 0) begin
      errors++;
      $display("FAIL single_frameerr: got %0d expected 0", feCnt);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    clearLog();
    sendFrame(8'hA5, 1'b1, st);
    sendFrame(8'h3C, 1'b1, st);
    idle(20);
    checks++;
    if (vq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses expected 2", vq.size());
    end else begin
      checks++;
      if (vq[0] !== 8'hA5 || vq[1] !== 8'h3C) begin
        errors++;
        $display("FAIL b2b_data: got %h %h expected a5 3c", vq[0], vq[1]);
      end
      checks++;
      if (vt[1] - vt[0] != 160) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles expected 160", vt[1] - vt[0]);
      end
    end
  endtask

  task automatic test_bit_order();
    int st;
    logic [7:0] exp [3];
    exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
    clearLog();
    for (int i = 0; i < 3; i++) begin
      sendFrame(exp[i], 1'b1, st);
      idle(7);
    end
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL order_count: got %0d pulses expected 3", vq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vq[i] !== exp[i]) begin
          errors++;
          $display("FAIL order_byte%0d: got %h expected %h", i, vq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int st;
    int busyCycles;
    clearLog();
    busyCycles = 0;
    rxd = 1'b0;
    repeat (4) @(negedge clkMem);
    rxd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkMem);
      if (busy) busyCycles++;
    end
    checks++;
    if (busyCycles < 1 || busyCycles > 9) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles expected 1..9", busyCycles);
    end
    checks++;
    if (vq.size() != 0 || feCnt != 0) begin
      errors++;
      $display("FAIL glitch_strobe: got %0d valid %0d fe expected 0 0", vq.size(), feCnt);
    end
    sendFrame(8'h5A, 1'b1, st);
    idle(10);
    checks++;
    if (vq.size() != 1 || progData !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_next: got %0d pulses data %h expected 1 pulse 5a", vq.size(), progData);
    end
  endtask

  task automatic test_frame_err();
    int st;
    sendFrame(8'h11, 1'b1, st);
    idle(5);
    clearLog();
    sendFrame(8'hFF, 1'b0, st);
    repeat (400) @(negedge clkMem);
    checks++;
    if (feCnt != 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d pulses expected 1", feCnt);
    end
    checks++;
    if (vq.size() != 0 || progData !== 8'h11) begin
      errors++;
      $display("FAIL ferr_data: got %0d valid data %h expected 0 valid data 11", vq.size(), progData);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_break_busy: got %b expected 0", busy);
    end
    idle(20);
    clearLog();
    sendFrame(8'h22, 1'b1, st);
    idle(10);
    checks++;
    if (vq.size() != 1 || progData !== 8'h22 || feCnt != 0) begin
      errors++;
      $display("FAIL ferr_recover: got %0d valid data %h fe %0d expected 1 22 0",
               vq.size(), progData, feCnt);
    end
  endtask

  task automatic test_abort();
    int st;
    clearLog();
    rxd = 1'b0;
    repeat (16 * 5 + 8) @(negedge clkMem);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_en_busy_before: got %b expected 1", busy);
    end
    rxEn = 1'b0;
    @(negedge clkMem);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_en_busy_after: got %b expected 0", busy);
    end
    idle(200);
    rxEn = 1'b1;
    idle(10);
    checks++;
    if (vq.size() != 0 || feCnt != 0 || progData !== 8'h22) begin
      errors++;
      $display("FAIL abort_en_strobe: got %0d valid %0d fe data %h expected 0 0 22",
               vq.size(), feCnt, progData);
    end

    rxd = 1'b0;
    repeat (16 * 7 + 8) @(negedge clkMem);
    rst = 1'b1;
    @(negedge clkMem);
    checks++;
    if ({progData, progValid, frameErr, busy} !== 11'h000) begin
      errors++;
      $display("FAIL abort_rst_outputs: got data=%h v=%b fe=%b busy=%b expected 00/0/0/0",
               progData, progValid, frameErr, busy);
    end
    rst = 1'b0;
    idle(30);
    clearLog();
    sendFrame(8'h33, 1'b1, st);
    idle(10);
    checks++;
    if (vq.size() != 1 || progData !== 8'h33 || feCnt != 0) begin
      errors++;
      $display("FAIL abort_rst_next: got %0d valid data %h fe %0d expected 1 33 0",
               vq.size(), progData, feCnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bit_order();
    test_glitch();
    test_frame_err();
    test_abort();
    checks++;
    if (ruleViol != 0) begin
      errors++;
      $display("FAIL strobe_rules: got %0d violations expected 0", ruleViol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
